gas_id_bnn1_bnnromem: RTL and testbench

Sequential two-layer binarized neural network classifier for the gas-identification dataset, with all weights held in constant ROMs. It takes one 128-feature, 4-bit-per-feature sample held on a flat bus. It evaluates one hidden neuron per cycle, then one output class per cycle, and registers the argmax class index. It is a standalone inference leaf: the sample is held static, reset starts a new inference, and the result is read after a fixed latency.

---
 rtl/gas_id_bnn1_pkg.sv | 97 +++++++++
 rtl/gas_id_bnn1_bnnromem_hidden_mac.sv | 35 +++
 rtl/gas_id_bnn1_bnnromem.sv | 114 +++++++++++
 tb/tb_gas_id_bnn1_bnnromem.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/gas_id_bnn1_pkg.sv
// Shared definitions for the gas-identification binarized classifier.
// Holds the network dimensions, derived datapath widths, the sequencer
// state type and the constant weight/threshold ROMs of the trained model.
// Build option: GAS_ID_BNN1_DONE_EN (consumed by the top module only).
package gas_id_bnn1_pkg;

    localparam int unsigned FEAT_CNT   = 128;
    localparam int unsigned HIDDEN_CNT = 40;
    localparam int unsigned FEAT_BITS  = 4;
    localparam int unsigned CLASS_CNT  = 6;

    localparam int unsigned ACC_W = FEAT_BITS + $clog2(FEAT_CNT) + 1;
    localparam int unsigned SUM_W = $clog2(HIDDEN_CNT + 1);
    localparam int unsigned CLS_W = $clog2(CLASS_CNT);
    localparam int unsigned HID_W = $clog2(HIDDEN_CNT);
    localparam int unsigned BUS_W = FEAT_BITS * FEAT_CNT;

    typedef enum logic [1:0] {
        ST_HID  = 2'd0,
        ST_CLS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Layer-1 sign weights: bit i of row h set means feature i adds to neuron h.
    localparam logic [FEAT_CNT-1:0] W1 [HIDDEN_CNT] = '{
        128'h3a7f_91c4_5e2b_d806_7c19_e4a3_0bf5_628d,
        128'hc4e1_2b9a_76f0_3d58_a1e7_94c2_5f0b_8d36,
        128'h5b90_e37c_1da4_f862_0c5e_b7a9_3418_6fd2,
        128'h8f26_4ab1_d90e_57c3_e2a8_1b6f_c074_9d5a,
        128'h17dc_a058_3fb2_e691_4c7a_0d8e_b523_f6a9,
        128'he950_7b3c_a28d_1f64_96e0_c4b7_2a5d_830f,
        128'h26af_d17e_0c94_b35a_e8f1_6720_4dc9_5ab3,
        128'hb3c8_5f02_e96a_7d14_3b8c_f0a5_d612_e97c,
        128'h4e17_9ac6_b25f_08d3_7af4_1ce9_8b30_d56e,
        128'hd28b_06f5_4c3a_e917_5b06_a8d2_f41c_7e93,
        128'h71f4_c8a3_9e05_62bd_d137_5e8a_06fc_b249,
        128'ha605_3bd9_f14e_c782_28ec_9f31_b75a_0d64,
        128'h0bd9_e642_7a1f_35c8_b9a6_24d0_e3f7_5c18,
        128'h9c62_1fb8_d35e_a409_6e13_b7fa_50c2_8d9b,
        128'hf34a_8c17_60d9_eb25_c84f_1a62_9de0_37b5,
        128'h6817_d2ae_b94c_053f_a7d2_e6b0_41f8_9c3e,
        128'h2d9e_57f0_1a83_c6b4_3f6c_8d19_e75a_b024,
        128'hc571_a93d_e602_4bf8_915e_4ac7_0d3b_f68a,
        128'h49b3_0e6c_f75a_28d1_eb80_5d34_a6cf_1297,
        128'hae08_f4b5_3c71_9de6_0dc9_7f28_54ab_e31c,
        128'h1f6c_b28e_d043_a759_6a51_e3b4_c80f_2d97,
        128'h84d5_79a2_6eb1_0fc3_b92e_0a76_1fd4_c5e8,
        128'hd7a3_1c59_b8e4_62f0_478d_c1f5_e92a_6b03,
        128'h3c4e_e87b_05a9_d126_f034_9b6e_27c1_8da5,
        128'h902f_6d34_c7b8_e5a1_5ce7_238a_b64d_f019,
        128'h65b8_a3e1_2f4d_907c_89a3_f50c_d12e_4b76,
        128'hbae1_4d96_7053_cf28_1d58_6ec2_7f93_a04b,
        128'h0675_f2c8_e91a_3bd4_c629_a47d_3e0b_95f1,
        128'hf1ca_3b07_5dc6_a849_7ab4_0d9f_c568_e213,
        128'h5293_c8fe_a670_1d3b_e0f6_b251_8ac4_397d,
        128'h8e4d_16a0_9b3f_e572_32cd_f84e_a917_6b50,
        128'h2b06_e5d9_4c82_f1a7_d47b_1c03_f6e5_82a9,
        128'hc9f2_7a4b_d8e6_035c_6e8a_49b5_02d7_c13f,
        128'h7438_b1ce_26f5_9ad0_b315_e7c0_8f2a_d46e,
        128'ha1dc_49e3_f08b_67c2_0f96_d82b_c34e_17a5,
        128'h3f85_c62a_971d_b04e_e5a7_3061_9db8_4cf2,
        128'hd64b_0e7f_3ac9_285d_5c0e_a9f4_61b3_d827,
        128'h19e0_a5b6_c43f_de71_a8d3_17ec_f540_6b9c,
        128'he72c_d891_5fa0_4b36_4e71_c2a6_b98f_30d5,
        128'h4a57_3f28_e1d6_c90b_9b2c_f758_0e6d_a4e1
    };

    // Layer-1 firing thresholds, compared against the signed accumulator.
    localparam logic signed [ACC_W-1:0] THR [HIDDEN_CNT] = '{
         12'sd12, -12'sd7,   12'sd3,  -12'sd21,  12'sd30, -12'sd2,   12'sd17, -12'sd33,
         12'sd0,   12'sd25, -12'sd14,  12'sd6,  -12'sd28,  12'sd9,  -12'sd1,   12'sd38,
        -12'sd19,  12'sd4,   12'sd22, -12'sd11,  12'sd15, -12'sd36,  12'sd1,  -12'sd5,
         12'sd27, -12'sd24,  12'sd8,  -12'sd16,  12'sd34, -12'sd9,   12'sd11, -12'sd30,
         12'sd20, -12'sd3,   12'sd5,  -12'sd26,  12'sd13, -12'sd18,  12'sd29, -12'sd12
    };

    // Layer-2 binary weights: bit h of row c is matched against hidden bit h.
    localparam logic [HIDDEN_CNT-1:0] W2 [CLASS_CNT] = '{
        40'h9a_3c5e_71b2,
        40'h45_e1a9_c836,
        40'hd3_7b04_5e9f,
        40'h2e_98f6_a143,
        40'hb6_4d27_0ce8,
        40'h71_c5b3_9f2a
    };

    // Number of set bits in a hidden-layer vector.
    function automatic logic [SUM_W-1:0] popcount(input logic [HIDDEN_CNT-1:0] v);
        logic [SUM_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(HIDDEN_CNT); i++) begin
            cnt = cnt + SUM_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gas_id_bnn1_bnnromem_hidden_mac.sv
// Combinational signed add/subtract of all features under one W1 row.
// Ports:
//   i_features  flat feature bus, feature i at [i*FEAT_BITS +: FEAT_BITS], unsigned
//   i_w_row     one W1 row; bit set adds the feature, clear subtracts it
//   o_acc_c     signed ACC_W-bit sum (cannot overflow at full scale)
module gas_id_bnn1_hidden_mac
    import gas_id_bnn1_pkg::*;
(
    input  logic        [BUS_W-1:0]    i_features,
    input  logic        [FEAT_CNT-1:0] i_w_row,
    output logic signed [ACC_W-1:0]    o_acc_c
);

    // Signed, zero-extended copies of each feature.
    logic signed [ACC_W-1:0] w_x [FEAT_CNT];

    always_comb begin
        for (int i = 0; i < int'(FEAT_CNT); i++) begin
            w_x[i] = $signed(ACC_W'(i_features[i*FEAT_BITS +: FEAT_BITS]));
        end
    end

    // Written as a linear sum; synthesis is free to rebalance it into a tree.
    always_comb begin
        o_acc_c = '0;
        for (int i = 0; i < int'(FEAT_CNT); i++) begin
            if (i_w_row[i]) begin
                o_acc_c = o_acc_c + w_x[i];
            end else begin
                o_acc_c = o_acc_c - w_x[i];
            end
        end
    end

endmodule

// File: rtl/gas_id_bnn1_bnnromem.sv
// Sequential two-layer binarized classifier for gas identification.
// One hidden neuron is evaluated per cycle (HIDDEN_CNT cycles), then one
// output class per cycle (CLASS_CNT cycles); the argmax index is registered.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset; also starts a new inference
//   features    FEAT_CNT x FEAT_BITS unsigned sample, held for the inference
//   prediction  registered winning class index, 0 until the result is ready
//   done        (only with GAS_ID_BNN1_DONE_EN) high once prediction is final
module gas_id_bnn1_bnnromem
    import gas_id_bnn1_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] features,
`ifdef GAS_ID_BNN1_DONE_EN
    output logic [CLS_W-1:0] prediction,
    output logic             done
`else
    output logic [CLS_W-1:0] prediction
`endif
);

    state_e                  r_state;
    logic [HID_W-1:0]        r_hid_cnt;
    logic [CLS_W-1:0]        r_cls_cnt;
    logic [HIDDEN_CNT-1:0]   r_hid;
    logic [SUM_W-1:0]        r_best;
    logic [CLS_W-1:0]        r_pred_int;
    logic [CLS_W-1:0]        r_prediction;
    logic                    r_done;

    logic [FEAT_CNT-1:0]     w_w1_row;
    logic signed [ACC_W-1:0] w_acc;
    logic                    w_hid_bit;
    logic [SUM_W-1:0]        w_score;
    logic                    w_better;
    logic                    w_hid_last;
    logic                    w_cls_last;

    assign w_w1_row = W1[r_hid_cnt];

    gas_id_bnn1_hidden_mac u_hidden_mac (
        .i_features (features),
        .i_w_row    (w_w1_row),
        .o_acc_c    (w_acc)
    );

    assign w_hid_bit  = (w_acc >= THR[r_hid_cnt]);
    assign w_hid_last = (r_hid_cnt == HID_W'(HIDDEN_CNT - 1));
    assign w_cls_last = (r_cls_cnt == CLS_W'(CLASS_CNT - 1));

    // XNOR-popcount agreement between the hidden vector and the current class row.
    assign w_score  = popcount(~(r_hid ^ W2[r_cls_cnt]));
    // Strict greater-than keeps the lower index on ties.
    assign w_better = (r_cls_cnt == '0) || (w_score > r_best);

    // Sequencer: HID -> CLS -> DONE, restarted only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HID;
            r_hid_cnt    <= '0;
            r_cls_cnt    <= '0;
            r_hid        <= '0;
            r_best       <= '0;
            r_pred_int   <= '0;
            r_prediction <= '0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_HID: begin
                    r_hid[r_hid_cnt] <= w_hid_bit;
                    if (w_hid_last) begin
                        r_hid_cnt <= '0;
                        r_state   <= ST_CLS;
                    end else begin
                        r_hid_cnt <= r_hid_cnt + HID_W'(1);
                    end
                end
                ST_CLS: begin
                    if (w_better) begin
                        r_best     <= w_score;
                        r_pred_int <= r_cls_cnt;
                    end
                    if (w_cls_last) begin
                        // Fold the last class in directly so the result lands this edge.
                        r_prediction <= w_better ? r_cls_cnt : r_pred_int;
                        r_done       <= 1'b1;
                        r_cls_cnt    <= '0;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cls_cnt <= r_cls_cnt + CLS_W'(1);
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    r_state <= ST_HID;
                end
            endcase
        end
    end

    assign prediction = r_prediction;

`ifdef GAS_ID_BNN1_DONE_EN
    assign done = r_done;
`else
    // Completion flag has no port in this build.
    logic w_done_unused;
    assign w_done_unused = r_done;
`endif

endmodule

// File: tb/tb_gas_id_bnn1_bnnromem.sv
module tb_gas_id_bnn1_bnnromem;
    import gas_id_bnn1_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [BUS_W-1:0] features = '0;
    logic [CLS_W-1:0] prediction;
`ifdef GAS_ID_BNN1_DONE_EN
    logic             done;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gas_id_bnn1_bnnromem dut (
        .clk        (clk),
        .rst        (rst),
        .features   (features),
`ifdef GAS_ID_BNN1_DONE_EN
        .prediction (prediction),
        .done       (done)
`else
        .prediction (prediction)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference classifier: plain integer arithmetic over the model tables.
    function automatic int ref_predict(input logic [BUS_W-1:0] f);
        int agree [CLASS_CNT];
        int hid   [HIDDEN_CNT];
        int acc, x, best, pred;
        for (int h = 0; h < int'(HIDDEN_CNT); h++) begin
            logic [FEAT_CNT-1:0] row;
            row = W1[h];
            acc = 0;
            for (int i = 0; i < int'(FEAT_CNT); i++) begin
                x = int'(f[i*FEAT_BITS +: FEAT_BITS]);
                acc += row[i] ? x : -x;
            end
            hid[h] = (acc >= int'(THR[h])) ? 1 : 0;
        end
        for (int c = 0; c < int'(CLASS_CNT); c++) begin
            logic [HIDDEN_CNT-1:0] w;
            w = W2[c];
            agree[c] = 0;
            for (int h = 0; h < int'(HIDDEN_CNT); h++) begin
                if (hid[h] == int'(w[h])) agree[c]++;
            end
        end
        best = -1;
        pred = 0;
        for (int c = 0; c < int'(CLASS_CNT); c++) begin
            if (agree[c] > best) begin
                best = agree[c];
                pred = c;
            end
        end
        return pred;
    endfunction

    // Reset one cycle, then watch latency, final value, hold and done.
    task automatic run_and_check(input logic [BUS_W-1:0] f, input string tag);
        int exp;
        exp = ref_predict(f);
        @(negedge clk);
        rst      = 1'b1;
        features = f;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1;
            if (e == 45) begin
                check_eq({tag, " pre45"}, 32'(prediction), 0);
`ifdef GAS_ID_BNN1_DONE_EN
                check_eq({tag, " done45"}, 32'(done), 0);
`endif
            end
            if (e == 46) begin
                check_eq({tag, " pred46"}, 32'(prediction), 32'(exp));
                check_eq({tag, " range"}, 32'(prediction < CLASS_CNT), 1);
`ifdef GAS_ID_BNN1_DONE_EN
                check_eq({tag, " done46"}, 32'(done), 1);
`endif
            end
            if (e == 60) begin
                check_eq({tag, " hold"}, 32'(prediction), 32'(exp));
            end
        end
    endtask

    function automatic logic [BUS_W-1:0] rand_feats();
        logic [BUS_W-1:0] f;
        for (int k = 0; k < int'(BUS_W / 32); k++) f[k*32 +: 32] = $urandom;
        return f;
    endfunction

    initial begin
        logic [BUS_W-1:0] f;
        logic [BUS_W-1:0] fa;

        // Reset held for several cycles.
        rst      = 1'b1;
        features = rand_feats();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_eq("reset pred", 32'(prediction), 0);
`ifdef GAS_ID_BNN1_DONE_EN
            check_eq("reset done", 32'(done), 0);
`endif
        end

        run_and_check('0, "zeros");
        f = '1;
        run_and_check(f, "all_f");

        // Saturated-extreme patterns: each feature 0 or 15.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < int'(FEAT_CNT); i++)
                f[i*FEAT_BITS +: FEAT_BITS] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
            run_and_check(f, "extreme");
        end

        for (int n = 0; n < 25; n++) begin
            run_and_check(rand_feats(), "random");
        end

        // Reset mid-inference, then a different sample must match its standalone result.
        fa = rand_feats();
        @(negedge clk);
        rst      = 1'b1;
        features = fa;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
        end
        check_eq("midrun pred", 32'(prediction), 0);
        run_and_check(rand_feats(), "after_abort");
        run_and_check(fa, "rerun_a");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
